// File: rtl/gpr_wb_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_wb_arbiter
//   Round-robin arbiter sharing the single write port of the 8 x 16-bit
//   general-purpose register file between NUM_REQ writeback sources.
//   Grants are combinational (valid/ready per requester); the write port
//   toward the register file is registered, one cycle after the accept.
//
// Parameters
//   NUM_REQ  number of writeback requesters (2..4)
//   CNT_W    width of the saturating contention counter
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-low reset
//   wb_hold         1 = issue no grant this cycle
//   req_valid       per-requester write request
//   req_dest        per-requester destination, 4 bits each
//   req_data        per-requester write data, 16 bits each
//   req_ready       one-hot grant
//   reg_write_en    registered write enable to the register file
//   reg_write_dest  registered write address
//   reg_write_data  registered write data
//   conflict_cnt    saturating count of accepting cycles with >=2 requesters
//   dest_err        (GPR_WB_DEST_CHECK_EN only) sticky out-of-range dest flag
//
// Build option
//   GPR_WB_DEST_CHECK_EN  when defined, a request with dest[3]==1 is granted
//                         and consumed but produces no register-file write,
//                         and sets the sticky dest_err output.
// ---------------------------------------------------------------------------
module gpr_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_hold,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_dest,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   reg_write_en,
  output logic [3:0]             reg_write_dest,
  output logic [15:0]            reg_write_data,
  output logic [CNT_W-1:0]       conflict_cnt
`ifdef GPR_WB_DEST_CHECK_EN
  ,
  output logic                   dest_err
`endif
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  // Counter increments stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic multi_valid(input logic [NUM_REQ-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += int'(v[i]);
    return (n >= 2);
  endfunction

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_found;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_ready;
  logic [3:0]         w_dest;
  logic [15:0]        w_data;
  logic               w_wr_ok;

  logic               r_we_p1;
  logic [3:0]         r_dest_p1;
  logic [15:0]        r_data_p1;
  logic [CNT_W-1:0]   r_cnt;

  // Grant stage: first valid requester at or after r_rr_ptr, wrapping.
  // Reset and wb_hold suppress the grant entirely, so ready never rises
  // while the block is held in reset.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found   = 1'b1;
        w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
    w_accept = w_found & ~wb_hold & reset;
    w_ready  = '0;
    if (w_accept) w_ready[w_gnt_idx] = 1'b1;
    w_dest   = req_dest[4*int'(w_gnt_idx) +: 4];
    w_data   = req_data[16*int'(w_gnt_idx) +: 16];
  end

`ifdef GPR_WB_DEST_CHECK_EN
  // Addresses 8..15 lie outside the 8-entry file: consume, but do not write.
  assign w_wr_ok = ~w_dest[3];
`else
  assign w_wr_ok = 1'b1;
`endif

  // Write-port stage: registered toward the register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we_p1   <= 1'b0;
      r_dest_p1 <= '0;
      r_data_p1 <= '0;
      r_cnt     <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_we_p1 <= w_accept & w_wr_ok;
      if (w_accept && w_wr_ok) begin
        r_dest_p1 <= w_dest;
        r_data_p1 <= w_data;
      end
      if (w_accept) r_rr_ptr <= PTR_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
      if (w_accept && multi_valid(req_valid)) r_cnt <= sat_inc(r_cnt);
    end
  end

`ifdef GPR_WB_DEST_CHECK_EN
  logic r_dest_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dest_err <= 1'b0;
    end else if (w_accept && !w_wr_ok) begin
      r_dest_err <= 1'b1;
    end
  end

  assign dest_err = r_dest_err;
`endif

  assign req_ready      = w_ready;
  assign reg_write_en   = r_we_p1;
  assign reg_write_dest = r_dest_p1;
  assign reg_write_data = r_data_p1;
  assign conflict_cnt   = r_cnt;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpr_wb_arbiter
//   Directed testbench for gpr_wb_arbiter with NUM_REQ=2 and a narrow
//   contention counter (CNT_W=3) so saturation is reachable quickly.
//   Inputs change 1 time unit after the rising edge; combinational grants
//   are sampled 1 unit later and registered outputs right after the edge.
//   Define GPR_WB_DEST_CHECK_EN to also exercise the dest_err option.
// ---------------------------------------------------------------------------
module tb_gpr_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 3;

  logic                  clk;
  logic                  reset;
  logic                  wb_hold;
  logic [NUM_REQ-1:0]    req_valid;
  logic [4*NUM_REQ-1:0]  req_dest;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  reg_write_en;
  logic [3:0]            reg_write_dest;
  logic [15:0]           reg_write_data;
  logic [CNT_W-1:0]      conflict_cnt;
`ifdef GPR_WB_DEST_CHECK_EN
  logic                  dest_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  gpr_wb_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_hold        (wb_hold),
    .req_valid      (req_valid),
    .req_dest       (req_dest),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .conflict_cnt   (conflict_cnt)
`ifdef GPR_WB_DEST_CHECK_EN
    ,
    .dest_err       (dest_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] d0, input logic [15:0] x0,
                         input logic [3:0] d1, input logic [15:0] x1);
    req_dest = {d1, d0};
    req_data = {x1, x0};
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] d,
                        input logic [15:0] x);
    chk({tag, "_we"},   32'(reg_write_en),   32'(we));
    chk({tag, "_dest"}, 32'(reg_write_dest), 32'(d));
    chk({tag, "_data"}, 32'(reg_write_data), 32'(x));
  endtask

  initial begin
    reset     = 1'b0;
    wb_hold   = 1'b0;
    req_valid = 2'b11;
    set_req(4'h0, 16'h0, 4'h0, 16'h0);

    // Reset: ready forced low even with both requesters valid.
    tick();
    #1 chk("rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk_wr("rst", 1'b0, 4'h0, 16'h0);
    chk("rst_cnt", 32'(conflict_cnt), 32'h0);

    // Idle after release.
    req_valid = 2'b00;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("idle_ready", 32'(req_ready), 32'h0);
      tick();
      chk("idle_we", 32'(reg_write_en), 32'h0);
      chk("idle_cnt", 32'(conflict_cnt), 32'h0);
    end

    // Single requester 0.
    req_valid = 2'b01;
    set_req(4'h3, 16'hA5A5, 4'h0, 16'h0);
    #1 chk("single0_ready", 32'(req_ready), 32'h1);
    tick();
    chk_wr("single0", 1'b1, 4'h3, 16'hA5A5);
    chk("single0_cnt", 32'(conflict_cnt), 32'h0);
    req_valid = 2'b00;
    #1 chk("single0_idle_ready", 32'(req_ready), 32'h0);
    tick();
    chk_wr("single0_hold", 1'b0, 4'h3, 16'hA5A5);

    // Single requester 1 (pointer now at 1, returns to 0 after).
    req_valid = 2'b10;
    set_req(4'h0, 16'h0, 4'h5, 16'h5555);
    #1 chk("single1_ready", 32'(req_ready), 32'h2);
    tick();
    chk_wr("single1", 1'b1, 4'h5, 16'h5555);
    req_valid = 2'b00;
    tick();

    // Contention: alternating grants 0,1,0,1 then one more to 0.
    req_valid = 2'b11;
    set_req(4'h1, 16'h1111, 4'h2, 16'h2222);
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      if (i % 2 == 0) chk_wr("rr", 1'b1, 4'h1, 16'h1111);
      else            chk_wr("rr", 1'b1, 4'h2, 16'h2222);
      chk("rr_cnt", 32'(conflict_cnt), 32'(i + 1));
    end

    // Hold for 3 cycles: no grant, pointer and count frozen at 1 / 5.
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ready", 32'(req_ready), 32'h0);
      tick();
      chk("hold_we", 32'(reg_write_en), 32'h0);
      chk("hold_cnt", 32'(conflict_cnt), 32'h5);
    end
    wb_hold = 1'b0;
    #1 chk("hold_rel_ready", 32'(req_ready), 32'h2);
    tick();
    chk_wr("hold_rel", 1'b1, 4'h2, 16'h2222);
    chk("hold_rel_cnt", 32'(conflict_cnt), 32'h6);

    // Reset mid-operation: accept from 0 (pointer -> 1), then reset.
    req_valid = 2'b01;
    set_req(4'h6, 16'hBEEF, 4'h2, 16'h2222);
    #1 chk("mid_ready", 32'(req_ready), 32'h1);
    tick();
    chk_wr("mid_acc", 1'b1, 4'h6, 16'hBEEF);
    reset     = 1'b0;
    req_valid = 2'b11;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    chk_wr("mid_rst", 1'b0, 4'h0, 16'h0);
    chk("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
    reset = 1'b1;

    // After release pointer restarts at 0; 9 contended accepts saturate at 7.
    set_req(4'h1, 16'h1111, 4'h2, 16'h2222);
    for (int i = 0; i < 9; i++) begin
      #1 chk("sat_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("sat_cnt", 32'(conflict_cnt), (i + 1 > 7) ? 32'h7 : 32'(i + 1));
    end
    req_valid = 2'b00;
    tick();

    // Out-of-range destination (dest[3]==1).
    req_valid = 2'b01;
    set_req(4'hC, 16'h1234, 4'h2, 16'h2222);
    #1 chk("oor_ready", 32'(req_ready), 32'h1);
    tick();
`ifdef GPR_WB_DEST_CHECK_EN
    chk("oor_we", 32'(reg_write_en), 32'h0);
    chk("oor_err", 32'(dest_err), 32'h1);
    req_valid = 2'b00;
    tick();
    tick();
    chk("oor_err_sticky", 32'(dest_err), 32'h1);
    reset = 1'b0;
    tick();
    chk("oor_err_rst", 32'(dest_err), 32'h0);
    reset = 1'b1;
`else
    chk_wr("oor", 1'b1, 4'hC, 16'h1234);
    req_valid = 2'b00;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
